// File: rtl/alu_seq.sv
// Handshaked ALU: registered result and flags, with iterative shifts (optional) and
// iterative trailing-equal-bit count (diff) trading latency for area.
module alu_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SEQ_SHIFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic [3:0]       alu_signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       flags
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpComp = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpDiff = 4'b1000;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        fl_q, fl_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [2:0]        flags_q, flags_d;

  logic [WIDTH:0]    sum;
  logic [SW-1:0]     shamt;
  logic [WIDTH-1:0]  res;
  logic              carry;
  logic              is_shift;
  logic              is_iter;
  logic [WIDTH-1:0]  step;
  logic [1:0]        fl_in;

  assign shamt    = ip2[SW-1:0];
  assign fl_in    = {ip1[WIDTH-1], (ip1 == '0)};
  assign in_ready = rst && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out      = out_q;
  assign flags    = flags_q;

  // Single-cycle result; with SEQ_SHIFT only a zero-amount shift lands here.
  always_comb begin
    sum   = {1'b0, ip1} + {1'b0, ip2};
    res   = '0;
    carry = 1'b0;
    case (alu_signal)
      OpAdd: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OpAnd:  res = ip1 & ip2;
      OpComp: res = ~ip2 + WIDTH'(1);
      OpXor:  res = ip1 ^ ip2;
      OpSll:  res = SEQ_SHIFT ? ip1 : (ip1 << shamt);
      OpSrl:  res = SEQ_SHIFT ? ip1 : (ip1 >> shamt);
      OpSra:  res = SEQ_SHIFT ? ip1 : $unsigned($signed(ip1) >>> shamt);
      default: res = '0;
    endcase
  end

  always_comb begin
    is_shift = (alu_signal == OpSll) || (alu_signal == OpSrl) || (alu_signal == OpSra);
    is_iter  = (alu_signal == OpDiff) || (SEQ_SHIFT && is_shift && (shamt != '0));
  end

  always_comb begin
    case (op_q)
      OpSll:   step = work_q << 1;
      OpSrl:   step = work_q >> 1;
      default: step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    out_d   = out_q;
    flags_d = flags_q;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          op_d = alu_signal;
          fl_d = fl_in;
          if (alu_signal == OpDiff) begin
            work_d  = ip1 ^ ip2;
            cnt_d   = '0;
            state_d = StBusy;
          end else if (is_iter) begin
            work_d  = ip1;
            cnt_d   = {1'b0, shamt};
            state_d = StBusy;
          end else begin
            out_d   = res;
            flags_d = {carry, fl_in};
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        if (op_q == OpDiff) begin
          if (work_q[0] || (cnt_q == CW'(WIDTH))) begin
            out_d   = WIDTH'(cnt_q);
            flags_d = {1'b0, fl_q};
            state_d = StDone;
          end else begin
            work_d = work_q >> 1;
            cnt_d  = cnt_q + CW'(1);
          end
        end else begin
          work_d = step;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            out_d   = step;
            flags_d = {1'b0, fl_q};
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      fl_q    <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the datapath ALU. It executes the same eight operations and flag semantics at configurable width. Results and flags are registered. Shifts (optionally) and trailing-equal-bit count (`diff`) run iteratively over multiple cycles, so the execute stage can trade area for latency. It sits between operand fetch and writeback and stalls the pipeline through valid/ready.

## Interface
- `WIDTH`, 32: operand/result width; power of two, 8..64.
- `SEQ_SHIFT`, 1: 1 = shifts iterate one bit per cycle; 0 = shifts complete in one cycle (barrel).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operands/op presented.
- `in_ready` out 1: block can accept; high only in IDLE.
- `ip1`, `ip2` in WIDTH: operands.
- `alu_signal` in 4: 0001 add, 0010 and, 0011 comp (two's complement of ip2), 0100 xor, 0101 sll, 0110 srl, 0111 sra (arithmetic on ip1), 1000 diff; others give result 0.
- `out_valid` out 1: result/flags valid.
- `out_ready` in 1: consumer takes result.
- `out` out WIDTH: registered result.
- `flags` out 3: [0] ip1==0, [1] ip1 MSB, [2] carry-out of add (0 for all other ops).

## Operation
- Acceptance: handshake on a rising edge with `in_valid && in_ready`. On acceptance, `ip1`, `ip2`, `alu_signal` and flags[1:0] are captured; later input changes are ignored.
- FSM states:
  - IDLE: `in_ready`=1.
    - Accept a single-cycle op → DONE, with `out`/`flags` loaded.
    - Accept an iterative op → BUSY.
  - BUSY: `in_ready`=0, `out_valid`=0; iterate.
  - DONE: `out_valid`=1.
    - On `out_ready`=1 → IDLE.
    - Otherwise hold `out`/`flags` stable.
- Single-cycle ops: add, and, comp, xor, undefined codes, and shifts when `SEQ_SHIFT`=0.
- Add: WIDTH+1-bit sum; `out` = low WIDTH bits; flags[2] = bit WIDTH.
- Shift amount: s = ip2[log2(WIDTH)-1:0]; upper ip2 bits are ignored.
- Iterative shift (`SEQ_SHIFT`=1):
  - s==0 → DONE directly, `out`=ip1.
  - Otherwise BUSY with work=ip1, cnt=s. Each cycle, shift work one bit (sll zero-fill, srl zero-fill, sra MSB-replicate) and decrement cnt.
  - When cnt reaches 0 → DONE, `out`=work.
- diff:
  - On acceptance: x = ip1^ip2, i=0 → BUSY.
  - Each BUSY cycle: if x[0]==1 or i==WIDTH → DONE with `out`=i, zero-extended. Else x>>=1, i++.
  - Result is the index of the lowest differing bit, or WIDTH when the operands are equal. The counter is log2(WIDTH)+1 bits.
- No op is dropped or reordered; at most one op is in flight.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `out`=0, `flags`=0, `out_valid`=0.
  - `in_ready` is forced to 0 while `rst`=0, so no acceptance occurs during reset.
  - Reset mid-BUSY or mid-DONE abandons the op with no output.
- Accepted at edge k:
  - Single-cycle op: `out_valid` high after edge k+1.
  - Iterative shift by s≥1: `out_valid` high after edge k+1+s.
  - diff with result d: `out_valid` high after edge k+2+d. Worst case (equal operands) is k+2+WIDTH.
- DONE → IDLE on the edge where `out_ready`=1. The next op can be accepted on the following edge, so minimum throughput is one op per 2 cycles.
- `out_ready` outside DONE has no effect. `in_valid` outside IDLE is not accepted, and the upstream stage must hold its inputs.
- `out` and `flags` change only on the DONE-entry edge and on reset.

## Test plan
1. WIDTH=32; add ip1=0xFFFFFFFF, ip2=1, `out_ready`=1 → out=0, flags=3'b110, `out_valid` one cycle after accept.
2. WIDTH=32, SEQ_SHIFT=1; sra ip1=0x80000000, ip2=0x00000024 (s=4) → out=0xF8000000 after 5 cycles, `in_ready`=0 throughout BUSY. Same op with SEQ_SHIFT=0 → same result after 1 cycle.
3. diff ip1=0x00000010, ip2=0 → out=4 at k+6. ip1=ip2=0x12345678 → out=32, flags[0]=0, at k+34.
4. Backpressure: comp ip2=5 with `out_ready` low for 10 cycles → out=0xFFFFFFFB held stable, `in_valid` ignored. Raising `out_ready` → IDLE next edge, next op accepted.
5. Reset with `rst`=0 in the middle of a 20-step shift → next edge gives out=0, flags=0, `out_valid`=0. After `rst`=1, a new xor 0xF0^0xFF returns 0x0F.
6. WIDTH=8: srl 0x80 with ip2=0x0F (s=7) → 0x01. Undefined code 4'b1111 → out=0, flags[2]=0.
